// File: rtl/clock_recovery_pkg.sv
// Shared widths, event payload and helpers for the io clock recovery block.
package clock_recovery_pkg;

  localparam int unsigned RATE_COUNTER_WIDTH = 16;

  typedef struct packed {
    logic rising;
    logic falling;
    logic any;
  } recovered_events_s;

  // Width of a match counter that must hold 0..lock_count inclusive
  function automatic int unsigned lock_cnt_width(input int unsigned lock_count);
    return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/clock_recovery_phase_rate_tracker.sv
// Holds one phase's measured length, compares each new measurement against it
// within a tolerance and declares lock after enough consecutive matches.
module clock_recovery_phase_rate_tracker
  import clock_recovery_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOLERANCE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_all,
  input  logic                          clear_lock,
  input  logic                          meas_valid,
  input  logic [RATE_COUNTER_WIDTH-1:0] meas,
  output logic [RATE_COUNTER_WIDTH-1:0] rate,
  output logic                          locked,
  output logic                          locked_nxt_c
);

  localparam int unsigned W  = RATE_COUNTER_WIDTH;
  localparam int unsigned MW = lock_cnt_width(LOCK_COUNT);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);

  logic [MW-1:0] match_q;
  logic [MW-1:0] match_nxt;
  logic [W-1:0]  rate_nxt;
  logic          have_rate_q;
  logic          have_rate_nxt;
  logic [W:0]    diff;
  logic [W:0]    abs_diff;
  logic          in_tol;

  // Clears take priority over a pending measurement
  always_comb begin
    diff          = {1'b0, meas} - {1'b0, rate};
    abs_diff      = diff[W] ? (~diff + (W+1)'(1)) : diff;
    in_tol        = have_rate_q && (abs_diff <= (W+1)'(TOLERANCE));
    match_nxt     = match_q;
    rate_nxt      = rate;
    have_rate_nxt = have_rate_q;
    if (clear_all) begin
      match_nxt     = '0;
      rate_nxt      = '0;
      have_rate_nxt = 1'b0;
    end else if (clear_lock) begin
      match_nxt = '0;
    end else if (meas_valid) begin
      rate_nxt      = meas;
      have_rate_nxt = 1'b1;
      if (in_tol) begin
        match_nxt = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
      end else begin
        match_nxt = '0;
      end
    end
    locked_nxt_c = (match_nxt == MATCH_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate        <= '0;
      match_q     <= '0;
      have_rate_q <= 1'b0;
      locked      <= 1'b0;
    end else begin
      rate        <= rate_nxt;
      match_q     <= match_nxt;
      have_rate_q <= have_rate_nxt;
      locked      <= locked_nxt_c;
    end
  end

endmodule

// File: rtl/clock_recovery.sv
// Synchronises an external io clock into the sys domain, emits per-edge pulses
// and measures/locks the high and low phase lengths in sys cycles.
module clock_recovery
  import clock_recovery_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOLERANCE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          recovery_en_i,
  input  logic                          clear_state_i,
  input  logic                          io_clk_i,
  output logic [2:0]                    recovered_events_o,
  output logic [RATE_COUNTER_WIDTH-1:0] high_rate_o,
  output logic [RATE_COUNTER_WIDTH-1:0] low_rate_o,
  output logic                          high_locked_o,
  output logic                          low_locked_o,
  output logic                          fully_locked_in_o,
  output logic                          rate_overflow_o
);

  localparam int unsigned W = RATE_COUNTER_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   prev_q;
  logic                   rise_c;
  logic                   fall_c;
  logic                   edge_c;
  logic                   sat_c;
  logic                   clear_lock_c;
  logic [W-1:0]           cnt_q;
  logic                   primed_q;
  logic                   meas_valid_q;
  logic                   meas_high_q;
  logic [W-1:0]           meas_q;
  recovered_events_s      events_q;
  logic                   high_lock_nxt;
  logic                   low_lock_nxt;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign rise_c       = sync_s & ~prev_q;
  assign fall_c       = ~sync_s & prev_q;
  assign edge_c       = rise_c | fall_c;
  assign sat_c        = recovery_en_i && !edge_c && (cnt_q == CNT_MAX);
  assign clear_lock_c = !recovery_en_i || sat_c;

  assign recovered_events_o = events_q;

  // Synchroniser and prev flop keep running while disabled so enabling never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q          <= '0;
      prev_q          <= 1'b0;
      cnt_q           <= '0;
      primed_q        <= 1'b0;
      meas_valid_q    <= 1'b0;
      meas_high_q     <= 1'b0;
      meas_q          <= '0;
      events_q        <= '0;
      rate_overflow_o <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], io_clk_i};
      prev_q       <= sync_s;
      events_q     <= '0;
      meas_valid_q <= 1'b0;
      if (clear_state_i) begin
        cnt_q           <= '0;
        primed_q        <= 1'b0;
        rate_overflow_o <= 1'b0;
      end else if (!recovery_en_i) begin
        cnt_q    <= '0;
        primed_q <= 1'b0;
      end else if (edge_c) begin
        events_q     <= '{rising: rise_c, falling: fall_c, any: 1'b1};
        cnt_q        <= '0;
        primed_q     <= 1'b1;
        meas_valid_q <= primed_q;
        meas_high_q  <= fall_c;
        meas_q       <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + W'(1);
      end else if (sat_c) begin
        rate_overflow_o <= 1'b1;
        primed_q        <= 1'b0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

  // A falling edge ends a high phase; a rising edge ends a low phase
  clock_recovery_phase_rate_tracker #(
    .LOCK_COUNT (LOCK_COUNT),
    .TOLERANCE  (TOLERANCE)
  ) u_high (
    .clk          (clk),
    .rst          (rst),
    .clear_all    (clear_state_i),
    .clear_lock   (clear_lock_c),
    .meas_valid   (meas_valid_q & meas_high_q),
    .meas         (meas_q),
    .rate         (high_rate_o),
    .locked       (high_locked_o),
    .locked_nxt_c (high_lock_nxt)
  );

  clock_recovery_phase_rate_tracker #(
    .LOCK_COUNT (LOCK_COUNT),
    .TOLERANCE  (TOLERANCE)
  ) u_low (
    .clk          (clk),
    .rst          (rst),
    .clear_all    (clear_state_i),
    .clear_lock   (clear_lock_c),
    .meas_valid   (meas_valid_q & ~meas_high_q),
    .meas         (meas_q),
    .rate         (low_rate_o),
    .locked       (low_locked_o),
    .locked_nxt_c (low_lock_nxt)
  );

  // Built from next-state so it moves in the same cycle as the per-phase locks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fully_locked_in_o <= 1'b0;
    end else begin
      fully_locked_in_o <= high_lock_nxt & low_lock_nxt;
    end
  end

endmodule
